// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg
//   Shared constants and types for the neural-network input path.
//   DATA_WIDTH     : fixed-point word width of each NNin element
//   NUM_INPUTS     : pixels per frame (28x28)
//   FRAC_BITS      : fractional bits of the NNin words
//   TIMEOUT_CYCLES : idle-cycle limit inside a partial frame (timeout build only)
//   loader_state_t : input loader FSM states
// ---------------------------------------------------------------------------
package nn_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int NUM_INPUTS     = 784;
  localparam int FRAC_BITS      = 8;
  localparam int TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    LOAD = 2'd0,  // accepting pixels into NNin
    FIRE = 2'd1,  // frame complete, NNvalid pulse
    WAIT = 2'd2   // network computing, input blocked
  } loader_state_t;

endpackage

// File: rtl/nn_pixel_fixed.sv
// ---------------------------------------------------------------------------
// nn_pixel_fixed
//   Combinational conversion of an unsigned 8-bit pixel to a signed
//   fixed-point word with fracBits fractional bits. The pixel is treated as
//   a fraction of 256, so it is zero-extended and shifted left by
//   (fracBits-8). With fracBits <= dataWidth-2 the MSB is always 0, so the
//   result is non-negative.
//   Ports:
//     pix  : in  8          unsigned pixel, 0..255
//     word : out dataWidth  fixed-point value
// ---------------------------------------------------------------------------
module nn_pixel_fixed #(
  parameter int dataWidth = 16,
  parameter int fracBits  = 8
) (
  input  logic [7:0]           pix,
  output logic [dataWidth-1:0] word
);

  logic [dataWidth-1:0] pix_ext;

  assign pix_ext = {{(dataWidth-8){1'b0}}, pix};
  assign word    = pix_ext << (fracBits - 8);

endmodule

// File: rtl/nn_input_loader.sv
// ---------------------------------------------------------------------------
// nn_input_loader
//   Upstream stage of the neural network top. Accepts a valid/ready pixel
//   stream, converts each pixel to fixed point and packs numInputs pixels
//   into the flat NNin vector. NNvalid pulses once per complete frame; NNin
//   then stays stable while the network computes, and the next frame is
//   accepted only after resultValid returns.
//
//   Optional feature: define LOADER_TIMEOUT_EN to drop a partial frame after
//   timeoutCycles idle cycles (frameErr pulse). Without it a partial frame
//   waits indefinitely and frameErr comes only from a pixLast mismatch.
//
//   Ports:
//     clk         : in   1                    system clock
//     reset       : in   1                    asynchronous, active-low reset
//     pixIn       : in   8                    unsigned pixel
//     pixValid    : in   1                    pixIn/pixLast valid
//     pixLast     : in   1                    final pixel of a frame
//     pixReady    : out  1                    loader accepts a pixel (state LOAD)
//     resultValid : in   1                    network finished
//     NNin        : out  dataWidth*numInputs  packed frame, pixel i at [i*dataWidth +: dataWidth]
//     NNvalid     : out  1                    one-cycle pulse, NNin holds a frame
//     busy        : out  1                    high in FIRE and WAIT
//     frameErr    : out  1                    one-cycle pulse, frame dropped
// ---------------------------------------------------------------------------
module nn_input_loader
  import nn_pkg::*;
#(
  parameter int dataWidth     = DATA_WIDTH,
  parameter int numInputs     = NUM_INPUTS,
  parameter int fracBits      = FRAC_BITS,
  parameter int timeoutCycles = TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     pixIn,
  input  logic                           pixValid,
  input  logic                           pixLast,
  output logic                           pixReady,
  input  logic                           resultValid,
  output logic [dataWidth*numInputs-1:0] NNin,
  output logic                           NNvalid,
  output logic                           busy,
  output logic                           frameErr
);

  localparam int              IDX_W    = $clog2(numInputs);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numInputs - 1);

  // Reject parameter sets the converter cannot represent without overflow.
  if (fracBits < 8 || fracBits > dataWidth - 2 || timeoutCycles < 1) begin : g_bad_cfg
    $error("nn_input_loader: invalid fracBits/dataWidth/timeoutCycles");
  end

  loader_state_t        state;
  logic [IDX_W-1:0]     idx;
  logic [dataWidth-1:0] word;
  logic                 beat;
  logic                 at_last;
  logic                 timeout_hit;

  nn_pixel_fixed #(
    .dataWidth (dataWidth),
    .fracBits  (fracBits)
  ) u_pixel_fixed (
    .pix  (pixIn),
    .word (word)
  );

  assign pixReady = (state == LOAD);
  assign beat     = pixValid && pixReady;
  assign at_last  = (idx == LAST_IDX);

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(timeoutCycles + 1);

  logic [TO_W-1:0] idle_cnt;
  logic            idle_run;

  // Counting only happens inside a started frame; a beat always wins over
  // the limit because timeout_hit is qualified with !beat.
  assign idle_run    = (state == LOAD) && (idx != '0) && !beat;
  assign timeout_hit = idle_run && (idle_cnt == TO_W'(timeoutCycles - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (!idle_run || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LOAD;
      idx      <= '0;
      // NOTE: wide data registers are usually left unreset; NNin is reset
      // here because an all-zero frame after reset is an observable output.
      NNin     <= '0;
      NNvalid  <= 1'b0;
      frameErr <= 1'b0;
      busy     <= 1'b0;
    end else begin
      NNvalid  <= 1'b0;
      frameErr <= 1'b0;
      case (state)
        LOAD: begin
          if (beat) begin
            NNin[idx*dataWidth +: dataWidth] <= word;
            if (pixLast && at_last) begin
              idx     <= '0;
              state   <= FIRE;
              NNvalid <= 1'b1;
              busy    <= 1'b1;
            end else if (pixLast || at_last) begin
              // Early or missing pixLast: drop the frame, keep stale slots.
              idx      <= '0;
              frameErr <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (timeout_hit) begin
            idx      <= '0;
            frameErr <= 1'b1;
          end
        end
        FIRE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (resultValid) begin
            state <= LOAD;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= LOAD;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_input_loader.sv
// ---------------------------------------------------------------------------
// tb_nn_input_loader
//   Scoreboard bench for nn_input_loader. Stimulus tasks push the expected
//   output event (complete frame or dropped frame) into a queue; a monitor
//   pops and compares whenever NNvalid or frameErr is seen. Directed checks
//   cover reset state, handshake timing and NNin stability.
//   Build with LOADER_TIMEOUT_EN to exercise the idle timeout (limit 16).
// ---------------------------------------------------------------------------
module tb_nn_input_loader;

  localparam int W  = 16;
  localparam int N  = 784;
  localparam int F  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     pixIn;
  logic           pixValid;
  logic           pixLast;
  logic           pixReady;
  logic           resultValid;
  logic [W*N-1:0] NNin;
  logic           NNvalid;
  logic           busy;
  logic           frameErr;

  nn_input_loader #(
    .dataWidth     (W),
    .numInputs     (N),
    .fracBits      (F),
    .timeoutCycles (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixIn       (pixIn),
    .pixValid    (pixValid),
    .pixLast     (pixLast),
    .pixReady    (pixReady),
    .resultValid (resultValid),
    .NNin        (NNin),
    .NNvalid     (NNvalid),
    .busy        (busy),
    .frameErr    (frameErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             is_frame;
    logic [W*N-1:0] data;
  } ev_t;

  ev_t            exp_q[$];
  int             n_vec = 0;
  int             n_err = 0;
  logic [W*N-1:0] cur_frame;
  ev_t            mon_ev;
  int             mon_bad;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stimulus patterns; values fit in 8 bits by construction.
  function automatic logic [7:0] pat(input int mode, input int i);
    case (mode)
      0:       pat = 8'(i % 256);
      1:       pat = 8'((i * 7 + 3) % 256);
      default: pat = 8'(255 - (i % 256));
    endcase
  endfunction

  function automatic logic [W-1:0] conv(input logic [7:0] p);
    logic [W-1:0] e;
    e    = {{(W-8){1'b0}}, p};
    conv = e << (F - 8);
  endfunction

  function automatic logic [W*N-1:0] frame_of(input int mode);
    logic [W*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = conv(pat(mode, i));
    return v;
  endfunction

  task automatic push_frame(input logic [W*N-1:0] d);
    ev_t e;
    e.is_frame = 1'b1;
    e.data     = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.is_frame = 1'b0;
    e.data     = '0;
    exp_q.push_back(e);
  endtask

  // One beat: drive at negedge, wait (bounded) for ready, return after the edge.
  task automatic send_pix(input logic [7:0] p, input bit last);
    int t;
    t = 0;
    @(negedge clk);
    pixValid = 1'b1;
    pixIn    = p;
    pixLast  = last;
    while (!pixReady && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!pixReady) check(1'b0, "ready_timeout", 32'(pixReady), 32'd1);
    @(posedge clk);
  endtask

  task automatic send_range(input int mode, input int from, input int to, input bit mark_last);
    for (int i = from; i <= to; i++) send_pix(pat(mode, i), mark_last && (i == to));
  endtask

  // Full frame with directed checks of the FIRE cycle and the first WAIT cycle.
  task automatic send_frame(input int mode);
    cur_frame = frame_of(mode);
    send_range(mode, 0, N - 2, 1'b0);
    push_frame(cur_frame);
    send_pix(pat(mode, N - 1), 1'b1);
    @(negedge clk);
    pixValid = 1'b0;
    pixLast  = 1'b0;
    check(NNvalid == 1'b1, "nnvalid_rise", 32'(NNvalid), 32'd1);
    check(busy == 1'b1, "busy_fire", 32'(busy), 32'd1);
    check(pixReady == 1'b0, "ready_fire", 32'(pixReady), 32'd0);
    @(negedge clk);
    check(NNvalid == 1'b0, "nnvalid_one_cycle", 32'(NNvalid), 32'd0);
    check(busy == 1'b1, "busy_wait", 32'(busy), 32'd1);
  endtask

  task automatic release_result();
    @(negedge clk);
    resultValid = 1'b1;
    @(negedge clk);
    resultValid = 1'b0;
    check(pixReady == 1'b1, "ready_after_result", 32'(pixReady), 32'd1);
    check(busy == 1'b0, "busy_after_result", 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset && (NNvalid || frameErr)) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_event", {30'd0, NNvalid, frameErr}, 32'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        check((NNvalid == mon_ev.is_frame) && (frameErr == !mon_ev.is_frame),
              "event_kind", {30'd0, NNvalid, frameErr}, mon_ev.is_frame ? 32'd2 : 32'd1);
        if (mon_ev.is_frame) begin
          mon_bad = -1;
          for (int i = 0; i < N; i++)
            if (mon_bad < 0 && NNin[i*W +: W] !== mon_ev.data[i*W +: W]) mon_bad = i;
          if (mon_bad < 0) check(1'b1, "frame_data", 32'd0, 32'd0);
          else check(1'b0, $sformatf("frame_slot_%0d", mon_bad),
                     32'(NNin[mon_bad*W +: W]), 32'(mon_ev.data[mon_bad*W +: W]));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset       = 1'b0;
    pixIn       = '0;
    pixValid    = 1'b0;
    pixLast     = 1'b0;
    resultValid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1. Reset state
    check(pixReady == 1'b1, "reset_ready", 32'(pixReady), 32'd1);
    check(NNvalid == 1'b0, "reset_nnvalid", 32'(NNvalid), 32'd0);
    check(busy == 1'b0, "reset_busy", 32'(busy), 32'd0);
    check(frameErr == 1'b0, "reset_frameerr", 32'(frameErr), 32'd0);
    check(NNin == '0, "reset_nnin_zero", 32'(NNin[31:0]), 32'd0);

    // 2. First frame, pixel i = i%256
    send_frame(0);
    check(NNin[5*W +: W] == 16'h0005, "slot5", 32'(NNin[5*W +: W]), 32'h0005);
    check(NNin[783*W +: W] == 16'h000F, "slot783", 32'(NNin[783*W +: W]), 32'h000F);

    // 3. Upstream holds valid data while the network computes
    @(negedge clk);
    pixValid = 1'b1;
    pixIn    = 8'hAA;
    pixLast  = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 0 || c == 49) check(pixReady == 1'b0, "ready_blocked", 32'(pixReady), 32'd0);
    end
    check(NNin == cur_frame, "nnin_stable_wait", 32'(NNin[31:0]), 32'(cur_frame[31:0]));
    check(busy == 1'b1, "busy_hold", 32'(busy), 32'd1);
    pixValid = 1'b0;
    release_result();
    send_frame(1);
    release_result();

    // resultValid in LOAD is ignored
    @(negedge clk);
    resultValid = 1'b1;
    @(negedge clk);
    resultValid = 1'b0;
    check(pixReady == 1'b1, "result_in_load", 32'(pixReady), 32'd1);

    // 4. Early pixLast on beat 10
    send_range(2, 0, 9, 1'b0);
    push_err();
    send_pix(pat(2, 10), 1'b1);
    @(negedge clk);
    pixValid = 1'b0;
    pixLast  = 1'b0;
    check(frameErr == 1'b1, "early_last_err", 32'(frameErr), 32'd1);
    check(NNvalid == 1'b0, "early_last_novalid", 32'(NNvalid), 32'd0);
    @(negedge clk);
    check(frameErr == 1'b0, "err_one_cycle", 32'(frameErr), 32'd0);
    send_frame(2);
    release_result();

    // 5. Full-length frame without pixLast
    send_range(1, 0, N - 2, 1'b0);
    push_err();
    send_pix(pat(1, N - 1), 1'b0);
    @(negedge clk);
    pixValid = 1'b0;
    check(frameErr == 1'b1, "missing_last_err", 32'(frameErr), 32'd1);
    check(pixReady == 1'b1, "missing_last_load", 32'(pixReady), 32'd1);
    send_frame(0);  // fires only if idx restarted at 0
    release_result();

    // Idle gap inside a partial frame
    send_range(1, 0, 2, 1'b0);
    @(negedge clk);
    pixValid = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    push_err();
    k = 0;
    while (k < 100) begin
      @(posedge clk);
      k++;
      #1;
      if (frameErr) break;
    end
    check(k == TO, "timeout_cycle", 32'(k), 32'(TO));
    send_frame(1);
    release_result();
`else
    repeat (100) @(negedge clk);
    check(frameErr == 1'b0, "no_timeout", 32'(frameErr), 32'd0);
    cur_frame = frame_of(1);
    send_range(1, 3, N - 2, 1'b0);
    push_frame(cur_frame);
    send_pix(pat(1, N - 1), 1'b1);
    @(negedge clk);
    pixValid = 1'b0;
    pixLast  = 1'b0;
    check(NNvalid == 1'b1, "resume_fire", 32'(NNvalid), 32'd1);
    release_result();
`endif

    // 6. Reset mid-frame
    send_range(0, 0, 399, 1'b0);
    @(negedge clk);
    pixValid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    check(NNin == '0, "midreset_nnin", 32'(NNin[31:0]), 32'd0);
    check(busy == 1'b0, "midreset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    send_frame(2);
    release_result();

    repeat (5) @(negedge clk);
    check(exp_q.size() == 0, "pending_events", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
